// File: rtl/rans_pkg.sv
// Shared definitions for the rANS encoder back end: default widths, packer
// FSM states, and the encoder byte-mask type.
package rans_pkg;

  localparam int unsigned DEF_SYMBOL_WIDTH = 8;
  localparam int unsigned DEF_OUT_BYTES    = 4;

  typedef enum logic {RUN, TAIL} pack_state_t;

  typedef logic [1:0] byte_mask_t;

  function automatic logic [1:0] popcount2(input byte_mask_t m);
    return {1'b0, m[0]} + {1'b0, m[1]};
  endfunction

endpackage

// File: rtl/rans_byte_packer.sv
// Packs the encoder's 0-2 renormalisation bytes per beat into dense
// little-endian AXI4-Stream words, with an end-of-stream flush.
module rans_byte_packer
  import rans_pkg::*;
#(
  parameter int unsigned SYMBOL_WIDTH = DEF_SYMBOL_WIDTH,
  parameter int unsigned OUT_BYTES    = DEF_OUT_BYTES
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  byte_mask_t                        valid_i,
  input  logic [2*SYMBOL_WIDTH-1:0]         enc_i,
  input  logic                              flush_i,
  output logic                              ready_o,
  output logic [OUT_BYTES*SYMBOL_WIDTH-1:0] m_tdata_o,
  output logic [OUT_BYTES-1:0]              m_tkeep_o,
  output logic                              m_tlast_o,
  output logic                              m_tvalid_o,
  input  logic                              m_tready_i
);

  localparam int unsigned SW = SYMBOL_WIDTH;
  localparam int unsigned CW = $clog2(OUT_BYTES);

  pack_state_t state_q, state_d;
  logic [SW-1:0] acc_q [0:OUT_BYTES-2];
  logic [SW-1:0] acc_d [0:OUT_BYTES-2];
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] tail_q, tail_d;

  logic [SW-1:0] ext [0:OUT_BYTES];
  logic [SW-1:0] first_byte, second_byte;
  logic [OUT_BYTES*SW-1:0] word;
  logic [OUT_BYTES-1:0]    keep_vec;
  logic                    out_free, accept, full;
  int unsigned             cnt_i, n_in, total;

  logic                    load;
  logic [OUT_BYTES*SW-1:0] out_data_d;
  logic [OUT_BYTES-1:0]    out_keep_d;
  logic                    out_last_d;

  always_comb begin
    out_free = !m_tvalid_o || m_tready_i;
    ready_o  = !rst_i && (state_q == RUN) && out_free;
    accept   = ready_o && ((valid_i != '0) || flush_i);

    cnt_i = 32'(cnt_q);
    n_in  = 32'(popcount2(valid_i));
    total = cnt_i + n_in;
    full  = (total >= OUT_BYTES);

    first_byte  = valid_i[0] ? enc_i[SW-1:0] : enc_i[2*SW-1:SW];
    second_byte = enc_i[2*SW-1:SW];

    // Merged view: held bytes, then this beat's bytes; slots past total stay 0.
    for (int unsigned i = 0; i < OUT_BYTES + 1; i++) ext[i] = '0;
    for (int unsigned i = 0; i < OUT_BYTES - 1; i++)
      if (i < cnt_i) ext[i] = acc_q[i];
    if (n_in >= 1) ext[cnt_i] = first_byte;
    if (n_in == 2) ext[cnt_i + 1] = second_byte;

    word     = '0;
    keep_vec = '0;
    for (int unsigned i = 0; i < OUT_BYTES; i++) begin
      word[i*SW +: SW] = ext[i];
      keep_vec[i]      = (i < total);
    end
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    tail_d     = tail_q;
    load       = 1'b0;
    out_data_d = '0;
    out_keep_d = '0;
    out_last_d = 1'b0;

    unique case (state_q)
      RUN: begin
        if (accept) begin
          if (full) begin
            load       = 1'b1;
            out_data_d = word;
            out_keep_d = '1;
            for (int unsigned i = 0; i < OUT_BYTES - 1; i++) acc_d[i] = '0;
            acc_d[0] = ext[OUT_BYTES];
            cnt_d    = CW'(total - OUT_BYTES);
          end else begin
            for (int unsigned i = 0; i < OUT_BYTES - 1; i++) acc_d[i] = ext[i];
            cnt_d = CW'(total);
          end

          // Flush acts on the state after this beat's bytes are merged in.
          if (flush_i) begin
            for (int unsigned i = 0; i < OUT_BYTES - 1; i++) acc_d[i] = '0;
            cnt_d = '0;
            if (full) begin
              if (total == OUT_BYTES) begin
                out_last_d = 1'b1;
              end else begin
                tail_d  = ext[OUT_BYTES];
                state_d = TAIL;
              end
            end else begin
              load       = 1'b1;
              out_data_d = word;
              out_keep_d = keep_vec;
              out_last_d = 1'b1;
            end
          end
        end
      end

      TAIL: begin
        if (out_free) begin
          load             = 1'b1;
          out_data_d[SW-1:0] = tail_q;
          out_keep_d[0]    = 1'b1;
          out_last_d       = 1'b1;
          tail_d           = '0;
          state_d          = RUN;
        end
      end

      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= RUN;
      acc_q   <= '{default: '0};
      cnt_q   <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      tail_q  <= tail_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_tvalid_o <= 1'b0;
      m_tdata_o  <= '0;
      m_tkeep_o  <= '0;
      m_tlast_o  <= 1'b0;
    end else if (load) begin
      m_tvalid_o <= 1'b1;
      m_tdata_o  <= out_data_d;
      m_tkeep_o  <= out_keep_d;
      m_tlast_o  <= out_last_d;
    end else if (m_tready_i) begin
      m_tvalid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rans_byte_packer.sv
// Scoreboard bench for rans_byte_packer: directed vectors plus a random
// byte-conservation run, checked by an independent output monitor.
module tb_rans_byte_packer;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [1:0]  valid_i;
  logic [15:0] enc_i;
  logic        flush_i;
  logic        ready_o;
  logic [31:0] m_tdata_o;
  logic [3:0]  m_tkeep_o;
  logic        m_tlast_o;
  logic        m_tvalid_o;
  logic        m_tready_i;

  exp_t        exp_q[$];
  logic [7:0]  bq[$];
  int          total_checks = 0;
  int          passed_checks = 0;
  int          tmode = 0;
  bit          model_on = 1'b0;

  rans_byte_packer #(.SYMBOL_WIDTH(8), .OUT_BYTES(4)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .valid_i    (valid_i),
    .enc_i      (enc_i),
    .flush_i    (flush_i),
    .ready_o    (ready_o),
    .m_tdata_o  (m_tdata_o),
    .m_tkeep_o  (m_tkeep_o),
    .m_tlast_o  (m_tlast_o),
    .m_tvalid_o (m_tvalid_o),
    .m_tready_i (m_tready_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total_checks++;
    if (act === req) passed_checks++;
    else $display("FAIL %s: actual %0h required %0h", name, act, req);
  endtask

  // Downstream ready: 0 = always ready, 1 = alternating, 2 = random
  initial begin
    m_tready_i = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (tmode)
        1:       m_tready_i = ~m_tready_i;
        2:       m_tready_i = 1'($urandom_range(0, 1));
        default: m_tready_i = 1'b1;
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst_i && m_tvalid_o) begin
      if (exp_q.size() == 0) begin
        total_checks++;
        $display("FAIL unexpected_word: actual %0h/%0h/%0b required none",
                 m_tdata_o, m_tkeep_o, m_tlast_o);
      end else if (m_tready_i) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("word", {27'd0, m_tdata_o, m_tkeep_o, m_tlast_o}, {27'd0, e});
      end else begin
        chk("held_word", {27'd0, m_tdata_o, m_tkeep_o, m_tlast_o}, {27'd0, exp_q[0]});
        chk("ready_while_stalled", 64'(ready_o), 64'd0);
      end
    end
  end

  task automatic push_exp(input logic [31:0] d, input logic [3:0] k, input logic l);
    exp_t e;
    e.data = d; e.keep = k; e.last = l;
    exp_q.push_back(e);
  endtask

  task automatic model_accept(input logic [1:0] m, input logic [15:0] d, input logic f);
    bit formed = 1'b0;
    exp_t e;
    logic [31:0] w;
    logic [3:0]  k;
    if (m[0]) bq.push_back(d[7:0]);
    if (m[1]) bq.push_back(d[15:8]);
    while (bq.size() >= 4) begin
      push_exp({bq[3], bq[2], bq[1], bq[0]}, 4'hF, 1'b0);
      repeat (4) void'(bq.pop_front());
      formed = 1'b1;
    end
    if (f) begin
      if (bq.size() == 0 && formed) begin
        e = exp_q.pop_back();
        e.last = 1'b1;
        exp_q.push_back(e);
      end else begin
        w = '0;
        k = '0;
        for (int i = 0; i < bq.size(); i++) begin
          w[i*8 +: 8] = bq[i];
          k[i] = 1'b1;
        end
        push_exp(w, k, 1'b1);
      end
      bq.delete();
    end
  endtask

  task automatic send(input logic [1:0] m, input logic [15:0] d, input logic f);
    int unsigned waited = 0;
    valid_i = m; enc_i = d; flush_i = f;
    while (1) begin
      @(negedge clk);
      if (ready_o) break;
      waited++;
      if (waited > 200) begin
        total_checks++;
        $display("FAIL send_timeout: actual ready_o=0 required ready_o=1 within 200 cycles");
        break;
      end
    end
    if (model_on) model_accept(m, d, f);
    @(posedge clk); #1;
    valid_i = 2'b00; flush_i = 1'b0;
  endtask

  task automatic drain(input string name);
    int unsigned waited = 0;
    while (exp_q.size() != 0 && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    total_checks++;
    if (exp_q.size() == 0) passed_checks++;
    else $display("FAIL %s_drain: actual %0d words pending required 0", name, exp_q.size());
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: actual simulation still running required finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_i = 1'b1; valid_i = '0; enc_i = '0; flush_i = 1'b0;
    #7;
    chk("reset_outputs", {m_tvalid_o, m_tlast_o, m_tkeep_o, m_tdata_o}, '0);
    chk("reset_ready", 64'(ready_o), 64'd0);
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    @(posedge clk); #1;

    // Four single-byte beats -> one full word
    push_exp(32'h44332211, 4'hF, 1'b0);
    send(2'b01, 16'h0011, 1'b0);
    send(2'b01, 16'h0022, 1'b0);
    send(2'b01, 16'h0033, 1'b0);
    chk("t1_no_early_word", 64'(m_tvalid_o), 64'd0);
    send(2'b01, 16'h0044, 1'b0);
    chk("t1_latency", 64'(m_tvalid_o), 64'd1);
    drain("t1");

    // Paired beats with flush leaving a 2-byte partial
    push_exp(32'hDDCCBBAA, 4'hF, 1'b0);
    push_exp(32'h0000FFEE, 4'h3, 1'b1);
    send(2'b11, 16'hBBAA, 1'b0);
    send(2'b11, 16'hDDCC, 1'b0);
    send(2'b11, 16'hFFEE, 1'b1);
    drain("t2");

    // Overflow into a tail word
    push_exp(32'h04030201, 4'hF, 1'b0);
    push_exp(32'h00000005, 4'h1, 1'b1);
    send(2'b01, 16'h0001, 1'b0);
    send(2'b01, 16'h0002, 1'b0);
    send(2'b01, 16'h0003, 1'b0);
    send(2'b11, 16'h0504, 1'b1);
    chk("t3_tail_ready_low", 64'(ready_o), 64'd0);
    @(posedge clk); #1;
    chk("t3_tail_ready_back", 64'(ready_o), 64'd1);
    drain("t3");

    // Empty stream flush
    push_exp(32'h00000000, 4'h0, 1'b1);
    send(2'b00, 16'h0000, 1'b1);
    drain("t4");

    // High-byte-only beats under alternating backpressure
    tmode = 1;
    push_exp(32'h77777777, 4'hF, 1'b0);
    for (int i = 0; i < 4; i++) send(2'b10, 16'h7700, 1'b0);
    drain("t5");

    // Random beats, byte conservation against the byte-queue model
    tmode = 2;
    model_on = 1'b1;
    for (int i = 0; i < 1000; i++)
      send(2'($urandom_range(1, 3)), 16'($urandom), 1'b0);
    send(2'b00, 16'h0000, 1'b1);
    drain("random");
    model_on = 1'b0;
    tmode = 0;
    repeat (2) @(posedge clk); #1;

    // Asynchronous reset mid-word, then a fresh stream from slot 0
    send(2'b01, 16'h00E1, 1'b0);
    send(2'b01, 16'h00E2, 1'b0);
    #2 rst_i = 1'b1;
    #1;
    chk("midreset_outputs", {m_tvalid_o, m_tlast_o, m_tkeep_o, m_tdata_o}, '0);
    chk("midreset_ready", 64'(ready_o), 64'd0);
    @(negedge clk);
    rst_i = 1'b0;
    @(posedge clk); #1;
    push_exp(32'hD4C3B2A1, 4'hF, 1'b0);
    send(2'b01, 16'h00A1, 1'b0);
    send(2'b01, 16'h00B2, 1'b0);
    send(2'b11, 16'hD4C3, 1'b0);
    drain("post_reset");

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
